// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU width, opcode and FSM enums, and the golden reference function
package alu_pkg;
   localparam int ALU_W = 8;

   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_NOTA, OP_AND, OP_SHL, OP_SHR, OP_OR, OP_XOR
   } alu_op_e;

   typedef enum logic {ST_RUN, ST_HALT} state_e;

   function automatic logic [ALU_W-1:0] alu_golden(input logic [ALU_W-1:0] a,
                                                   input logic [ALU_W-1:0] b,
                                                   input alu_op_e op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_NOTA: return ~a;
         OP_AND:  return a & b;
         OP_SHL:  return a << 1;
         OP_SHR:  return a >> 1;
         OP_OR:   return a | b;
         default: return a ^ b;
      endcase
   endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: small synchronous command FIFO with full/empty flags (D must be a power of two)
module alu_cmd_fifo #(
   parameter int W = 19,
   parameter int D = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(D);

   logic [W-1:0]  mem_q [D];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = cnt_q == (AW+1)'(D);
   assign empty_o = cnt_q == '0;
   assign data_o  = mem_q[rd_q];

   always_comb begin
      do_push = push_i && !full_o;
      do_pop  = pop_i && !empty_o;
      wr_d    = do_push ? wr_q + AW'(1) : wr_q;
      rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
      cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end
endmodule

// File: rtl/alu_stim_checker.sv
// alu_stim_checker: buffers host commands, drives them into the ALU and checks each result
// against the golden model after LAT cycles, halting on the first mismatch when STOP_ON_ERR.
module alu_stim_checker
   import alu_pkg::*;
#(
   parameter int unsigned LAT         = 1,
   parameter bit          STOP_ON_ERR = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [ALU_W-1:0] cmd_a,
   input  logic [ALU_W-1:0] cmd_b,
   input  logic [2:0]       cmd_op,
   output logic [ALU_W-1:0] alu_a,
   output logic [ALU_W-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [ALU_W-1:0] alu_r,
   output logic             res_valid,
   output logic [ALU_W-1:0] res_data,
   output logic [ALU_W-1:0] res_expected,
   output logic             res_mismatch,
   output logic [ALU_W-1:0] err_count,
   output logic             halted,
   input  logic             clear
);
   localparam int CW = 2 * ALU_W + 3;

   state_e                      state_q, state_d;
   logic                        full, empty, issue, exit_v, mm;
   logic [CW-1:0]               head;
   logic [ALU_W-1:0]            gold;
   logic [ALU_W-1:0]            alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [2:0]                  alu_op_q, alu_op_d;
   logic [LAT-1:0]              vld_q, vld_d;
   logic [LAT:0]                vld_sh;
   logic [LAT-1:0][ALU_W-1:0]   exp_q, exp_d;
   logic [LAT:0][ALU_W-1:0]     exp_sh;
   logic                        res_valid_q, res_valid_d, res_mm_q, res_mm_d;
   logic [ALU_W-1:0]            res_data_q, res_data_d, res_exp_q, res_exp_d;
   logic [ALU_W-1:0]            err_q, err_d;
   logic                        halt_req_q, halt_req_d;

   alu_cmd_fifo #(.W(CW), .D(4)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (cmd_valid && cmd_ready),
      .pop_i   (issue),
      .data_i  ({cmd_a, cmd_b, cmd_op}),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign cmd_ready    = !full && rst_n;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_op       = alu_op_q;
   assign res_valid    = res_valid_q;
   assign res_data     = res_data_q;
   assign res_expected = res_exp_q;
   assign res_mismatch = res_mm_q;
   assign err_count    = err_q;
   assign halted       = state_q == ST_HALT;

   // Issue is gated on the next state so a registered mismatch stops issuing at once,
   // while a clear in the same cycle lets issuing resume immediately.
   always_comb begin
      state_d     = clear ? ST_RUN : (halt_req_q && STOP_ON_ERR) ? ST_HALT : state_q;
      issue       = !empty && state_d == ST_RUN;
      gold        = alu_golden(head[CW-1 -: ALU_W], head[3 +: ALU_W], alu_op_e'(head[2:0]));
      alu_a_d     = issue ? head[CW-1 -: ALU_W] : alu_a_q;
      alu_b_d     = issue ? head[3 +: ALU_W] : alu_b_q;
      alu_op_d    = issue ? head[2:0] : alu_op_q;
      vld_sh      = {vld_q, issue};
      vld_d       = vld_sh[LAT-1:0];
      exp_sh      = {exp_q, gold};
      exp_d       = exp_sh[LAT-1:0];
      exit_v      = vld_q[LAT-1];
      mm          = exit_v && (alu_r != exp_q[LAT-1]);
      res_valid_d = exit_v;
      res_data_d  = exit_v ? alu_r : res_data_q;
      res_exp_d   = exit_v ? exp_q[LAT-1] : res_exp_q;
      res_mm_d    = mm;
      err_d       = clear ? '0 : (mm && err_q != '1) ? err_q + ALU_W'(1) : err_q;
      halt_req_d  = mm && !clear;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         vld_q       <= '0;
         exp_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_exp_q   <= '0;
         res_mm_q    <= 1'b0;
         err_q       <= '0;
         halt_req_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         vld_q       <= vld_d;
         exp_q       <= exp_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_exp_q   <= res_exp_d;
         res_mm_q    <= res_mm_d;
         err_q       <= err_d;
         halt_req_q  <= halt_req_d;
      end
   end
endmodule

// File: tb/tb_alu_stim_checker.sv
// tb_alu_stim_checker: directed checks of alu_stim_checker at LAT=1 (halting) and LAT=3 (non-halting)
module tb_alu_stim_checker;
   typedef struct { int cyc; logic [7:0] d; logic [7:0] e; logic m; } rec_t;

   logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, clear = 1'b0;
   logic [7:0] cmd_a = '0, cmd_b = '0;
   logic [2:0] cmd_op = '0;
   logic       bug_add = 1'b0, inv_all = 1'b0;
   logic       rdy1, rv1, mm1, h1, rdy3, rv3, mm3, h3;
   logic [7:0] a1, b1, r1, rd1, re1, ec1, a3, b3, r3, rd3, re3, ec3, p1, p2;
   logic [2:0] op1, op3;
   int         cyc = 0, n_cmp = 0, n_bad = 0;
   rec_t       q1[$], q3[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU with optional fault modes: ADD returns ~A, or every result inverted.
   function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op, input logic bug, input logic inv);
      logic [7:0] r;
      case (op)
         3'd0: r = bug ? ~a : a + b;
         3'd1: r = a - b;
         3'd2: r = ~a;
         3'd3: r = a & b;
         3'd4: r = {a[6:0], 1'b0};
         3'd5: r = {1'b0, a[7:1]};
         3'd6: r = a | b;
         default: r = a ^ b;
      endcase
      return inv ? ~r : r;
   endfunction

   assign r1 = model(a1, b1, op1, bug_add, inv_all);
   always @(posedge clk) begin
      p1 <= model(a3, b3, op3, bug_add, inv_all);
      p2 <= p1;
   end
   assign r3 = p2;

   alu_stim_checker u_d1 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_r(r1),
      .res_valid(rv1), .res_data(rd1), .res_expected(re1), .res_mismatch(mm1),
      .err_count(ec1), .halted(h1), .clear(clear)
   );

   alu_stim_checker #(.LAT(3), .STOP_ON_ERR(1'b0)) u_d3 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy3),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(a3), .alu_b(b3), .alu_op(op3), .alu_r(r3),
      .res_valid(rv3), .res_data(rd3), .res_expected(re3), .res_mismatch(mm3),
      .err_count(ec3), .halted(h3), .clear(clear)
   );

   always @(negedge clk) begin
      if (rv1) q1.push_back('{cyc, rd1, re1, mm1});
      if (rv3) q3.push_back('{cyc, rd3, re3, mm3});
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; clear = 1'b0; bug_add = 1'b0; inv_all = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      q1.delete();
      q3.delete();
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, output int k);
      int n = 0;
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      while (!rdy1 && n < 20) begin
         tick(1);
         n++;
      end
      n_cmp++;
      if (n >= 20) begin n_bad++; $display("FAIL send_timeout: cmd_ready=%b required 1", rdy1); end
      tick(1);
      k = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic force_halt();
      int k;
      inv_all = 1'b1;
      send(8'h01, 8'h01, 3'd0, k);
      tick(3);
      inv_all = 1'b0;
      n_cmp++;
      if (h1 !== 1'b1) begin n_bad++; $display("FAIL force_halt: halted=%b required 1", h1); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b1; cmd_a = 8'h12; cmd_b = 8'h34; cmd_op = 3'd0;
      tick(2);
      n_cmp++;
      if ({rv1, rd1, re1, mm1, ec1, h1, a1, b1, op1} !== '0) begin
         n_bad++; $display("FAIL reset_outputs: got %h required 0", {rv1, rd1, re1, mm1, ec1, h1, a1, b1, op1});
      end
      n_cmp++;
      if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL reset_ready: cmd_ready=%b required 0", rdy1); end
      cmd_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: cmd_ready=%b required 1", rdy1); end
      tick(4);
      n_cmp++;
      if (q1.size() !== 0) begin n_bad++; $display("FAIL reset_no_accept: results=%0d required 0", q1.size()); end
   endtask

   task automatic test_all_ops();
      logic [7:0] exp_r [8] = '{8'hA5, 8'h2F, 8'h95, 8'h2A, 8'hD4, 8'h35, 8'h7B, 8'h51};
      int k, k0 = 0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send(8'h6A, 8'h3B, 3'(i), k);
         if (i == 0) k0 = k;
      end
      tick(6);
      n_cmp++;
      if (q1.size() !== 8) begin
         n_bad++; $display("FAIL ops_count: results=%0d required 8", q1.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (q1[i].d !== exp_r[i]) begin n_bad++; $display("FAIL ops_data[%0d]: got %h required %h", i, q1[i].d, exp_r[i]); end
            n_cmp++;
            if (q1[i].m !== 1'b0) begin n_bad++; $display("FAIL ops_mismatch[%0d]: got %b required 0", i, q1[i].m); end
            n_cmp++;
            if (q1[i].cyc !== k0 + 2 + i) begin n_bad++; $display("FAIL ops_timing[%0d]: cycle %0d required %0d", i, q1[i].cyc, k0 + 2 + i); end
         end
      end
      n_cmp++;
      if (ec1 !== 8'd0) begin n_bad++; $display("FAIL ops_errcount: got %0d required 0", ec1); end
      n_cmp++;
      if ({a1, op1} !== {8'h6A, 3'd7}) begin n_bad++; $display("FAIL ops_hold: alu_a/op %h/%0d required 6a/7", a1, op1); end
   endtask

   task automatic test_bug_halt();
      int k;
      do_reset();
      bug_add = 1'b1;
      send(8'h6A, 8'h3B, 3'd0, k);
      send(8'h6A, 8'h3B, 3'd1, k);
      send(8'h6A, 8'h3B, 3'd3, k);
      tick(5);
      n_cmp++;
      if (q1.size() !== 2) begin
         n_bad++; $display("FAIL bug_count: results=%0d required 2", q1.size());
      end else begin
         n_cmp++;
         if ({q1[0].d, q1[0].e, q1[0].m} !== {8'h95, 8'hA5, 1'b1}) begin
            n_bad++; $display("FAIL bug_add_result: data/exp/mm %h/%h/%b required 95/a5/1", q1[0].d, q1[0].e, q1[0].m);
         end
         n_cmp++;
         if ({q1[1].d, q1[1].m} !== {8'h2F, 1'b0}) begin
            n_bad++; $display("FAIL bug_sub_inflight: data/mm %h/%b required 2f/0", q1[1].d, q1[1].m);
         end
      end
      n_cmp++;
      if ({ec1, h1} !== {8'd1, 1'b1}) begin n_bad++; $display("FAIL bug_err_halt: err/halted %0d/%b required 1/1", ec1, h1); end
      n_cmp++;
      if (op1 !== 3'd1) begin n_bad++; $display("FAIL bug_no_issue: alu_op=%0d required 1", op1); end
      bug_add = 1'b0;
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      n_cmp++;
      if ({ec1, h1} !== {8'd0, 1'b0}) begin n_bad++; $display("FAIL bug_clear: err/halted %0d/%b required 0/0", ec1, h1); end
      tick(3);
      n_cmp++;
      if (q1.size() !== 3 || q1[q1.size()-1].d !== 8'h2A) begin
         n_bad++; $display("FAIL bug_resume: results=%0d required 3 ending in 2a", q1.size());
      end
   endtask

   task automatic test_fifo_full();
      do_reset();
      force_halt();
      q1.delete();
      for (int i = 0; i < 5; i++) begin
         cmd_a = 8'(i + 1); cmd_b = 8'h10; cmd_op = 3'd0; cmd_valid = 1'b1;
         n_cmp++;
         if (rdy1 !== (i < 4)) begin n_bad++; $display("FAIL fifo_ready[%0d]: cmd_ready=%b required %b", i, rdy1, i < 4); end
         tick(1);
      end
      cmd_valid = 1'b0;
      tick(2);
      n_cmp++;
      if (q1.size() !== 0) begin n_bad++; $display("FAIL fifo_halted_issue: results=%0d required 0", q1.size()); end
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      tick(6);
      n_cmp++;
      if (q1.size() !== 4) begin
         n_bad++; $display("FAIL fifo_drain_count: results=%0d required 4", q1.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (q1[i].d !== 8'(8'h11 + i)) begin n_bad++; $display("FAIL fifo_drain[%0d]: got %h required %h", i, q1[i].d, 8'(8'h11 + i)); end
         end
      end
      n_cmp++;
      if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL fifo_ready_after: cmd_ready=%b required 1", rdy1); end
   endtask

   task automatic test_wrap();
      int k;
      do_reset();
      send(8'hFF, 8'h01, 3'd0, k);
      send(8'h00, 8'h01, 3'd1, k);
      tick(4);
      n_cmp++;
      if (q1.size() !== 2 || {q1[0].d, q1[1].d, q1[0].m, q1[1].m} !== {8'h00, 8'hFF, 2'b00}) begin
         n_bad++; $display("FAIL wrap: results=%0d required 2 with data 00,ff no mismatch", q1.size());
      end
   endtask

   task automatic test_clear_race();
      int k;
      do_reset();
      inv_all = 1'b1;
      send(8'h01, 8'h01, 3'd0, k);
      tick(1);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      inv_all = 1'b0;
      n_cmp++;
      if ({rv1, mm1, ec1} !== {1'b1, 1'b1, 8'd0}) begin
         n_bad++; $display("FAIL race_clear_wins: valid/mm/err %b/%b/%0d required 1/1/0", rv1, mm1, ec1);
      end
      tick(2);
      n_cmp++;
      if (h1 !== 1'b0) begin n_bad++; $display("FAIL race_stays_run: halted=%b required 0", h1); end
      send(8'h02, 8'h03, 3'd0, k);
      tick(3);
      n_cmp++;
      if (q1.size() !== 2 || q1[1].d !== 8'h05) begin n_bad++; $display("FAIL race_resume: results=%0d required 2 ending in 05", q1.size()); end
   endtask

   task automatic test_reset_mid();
      int k;
      do_reset();
      force_halt();
      for (int i = 0; i < 4; i++) send(8'(8'h21 + i), 8'h00, 3'd6, k);
      q1.delete();
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      rst_n = 1'b0;
      tick(1);
      n_cmp++;
      if ({rv1, rd1, re1, mm1, ec1, h1, a1, b1, op1} !== '0) begin
         n_bad++; $display("FAIL midreset_outputs: got %h required 0", {rv1, rd1, re1, mm1, ec1, h1, a1, b1, op1});
      end
      tick(1);
      rst_n = 1'b1;
      tick(4);
      n_cmp++;
      if (q1.size() !== 0) begin n_bad++; $display("FAIL midreset_discard: results=%0d required 0", q1.size()); end
      send(8'h40, 8'h02, 3'd0, k);
      tick(3);
      n_cmp++;
      if (q1.size() !== 1 || q1[0].d !== 8'h42 || q1[0].cyc !== k + 2) begin
         n_bad++; $display("FAIL midreset_next: results=%0d required one 42 at cycle %0d", q1.size(), k + 2);
      end
   endtask

   task automatic test_lat3();
      int k;
      do_reset();
      send(8'h10, 8'h20, 3'd0, k);
      tick(6);
      n_cmp++;
      if (q3.size() !== 1) begin
         n_bad++; $display("FAIL lat3_count: results=%0d required 1", q3.size());
      end else begin
         n_cmp++;
         if (q3[0].cyc !== k + 4) begin n_bad++; $display("FAIL lat3_timing: cycle %0d required %0d", q3[0].cyc, k + 4); end
         n_cmp++;
         if ({q3[0].d, q3[0].m} !== {8'h30, 1'b0}) begin n_bad++; $display("FAIL lat3_data: data/mm %h/%b required 30/0", q3[0].d, q3[0].m); end
      end
   endtask

   task automatic test_saturate();
      int acc = 0, n = 0, nm = 0;
      do_reset();
      inv_all = 1'b1;
      cmd_a = 8'h05; cmd_b = 8'h03; cmd_op = 3'd0; cmd_valid = 1'b1;
      while (acc < 300 && n < 1000) begin
         if (rdy3) acc++;
         tick(1);
         n++;
      end
      cmd_valid = 1'b0;
      tick(8);
      inv_all = 1'b0;
      n_cmp++;
      if (acc !== 300) begin n_bad++; $display("FAIL sat_accept: accepted %0d required 300", acc); end
      foreach (q3[i]) if (q3[i].m) nm++;
      n_cmp++;
      if (nm !== 300) begin n_bad++; $display("FAIL sat_mismatches: got %0d required 300", nm); end
      n_cmp++;
      if ({ec3, h3} !== {8'd255, 1'b0}) begin n_bad++; $display("FAIL sat_errcount: err/halted %0d/%b required 255/0", ec3, h3); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_all_ops();
      test_bug_halt();
      test_fifo_full();
      test_wrap();
      test_clear_race();
      test_reset_mid();
      test_lat3();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
